// File: rtl/console_in_fifo.sv
// console_in_fifo: byte queue between the UART receiver and the
// Wrapper console input, presenting bytes with a four-phase ack.
module console_in_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic [7:0]        CONSOLE_IN,
    output logic              CONSOLE_IN_valid,
    input  logic              CONSOLE_IN_ack,
    output logic [ADDR_W:0]   COUNT,
    output logic              FULL,
    output logic              OVERFLOW
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        WAIT_ACK_LOW
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    state_t state, state_d;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              load, pop, wr_en, drop;

    // A full FIFO still accepts a byte when the head leaves on the same edge
    assign wr_en = RX_VALID && (!FULL || pop);
    assign drop  = RX_VALID && FULL && !pop;

    // Handshake state register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_d;
    end

    // Next state plus load/pop strobes; a present waits for ack low so a stale ack is ignored
    always_comb begin
        state_d = state;
        load    = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (COUNT != '0 && !CONSOLE_IN_ack) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (CONSOLE_IN_ack) begin
                    pop     = 1'b1;
                    state_d = WAIT_ACK_LOW;
                end
            end
            WAIT_ACK_LOW: begin
                if (!CONSOLE_IN_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte storage; contents need no reset
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= RX_DATA;
    end

    // Pointers, occupancy, full and sticky overflow
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            FULL     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_en && !pop) begin
                COUNT <= COUNT + CNT_ONE;
                FULL  <= (COUNT + CNT_ONE) == FULL_CNT;
            end else if (pop && !wr_en) begin
                COUNT <= COUNT - CNT_ONE;
                FULL  <= 1'b0;
            end
            if (drop) OVERFLOW <= 1'b1;
        end
    end

    // Registered console outputs; data holds its last value after the pop
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            CONSOLE_IN       <= 8'h00;
            CONSOLE_IN_valid <= 1'b0;
        end else if (load) begin
            CONSOLE_IN       <= mem[rd_ptr];
            CONSOLE_IN_valid <= 1'b1;
        end else if (pop) begin
            CONSOLE_IN_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_console_in_fifo.sv
// tb_console_in_fifo: directed and random stimulus for console_in_fifo
// checked every cycle against a queue-based reference model.
module tb_console_in_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              CLK = 1'b0;
    logic              RESETn = 1'b0;
    logic [7:0]        RX_DATA = 8'h00;
    logic              RX_VALID = 1'b0;
    logic              CONSOLE_IN_ack = 1'b0;
    logic [7:0]        CONSOLE_IN;
    logic              CONSOLE_IN_valid;
    logic [ADDR_W:0]   COUNT;
    logic              FULL;
    logic              OVERFLOW;

    console_in_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID),
        .CONSOLE_IN(CONSOLE_IN),
        .CONSOLE_IN_valid(CONSOLE_IN_valid),
        .CONSOLE_IN_ack(CONSOLE_IN_ack),
        .COUNT(COUNT),
        .FULL(FULL),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of held bytes plus handshake phase
    // ph 0 = nothing shown, 1 = byte shown, 2 = popped, waiting ack low
    logic [7:0] q[$];
    int         ph;
    logic [7:0] m_out;
    bit         m_ovf;

    task automatic model_reset();
        q.delete();
        ph    = 0;
        m_out = 8'h00;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit a);
        bit take, acc;
        take = (ph == 1) && a;
        acc  = v && (q.size() < DEPTH || take);
        if (v && !acc) m_ovf = 1'b1;
        case (ph)
            0: if (q.size() > 0 && !a) begin
                m_out = q[0];
                ph    = 1;
            end
            1: if (a) begin
                q.delete(0);
                ph = 2;
            end
            default: if (!a) ph = 0;
        endcase
        if (acc) q.push_back(d);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"}, CONSOLE_IN, m_out);
        chk({tag, "_valid"}, CONSOLE_IN_valid, (ph == 1));
        chk({tag, "_count"}, COUNT, q.size());
        chk({tag, "_full"}, FULL, (q.size() == DEPTH));
        chk({tag, "_ovf"}, OVERFLOW, m_ovf);
    endtask

    task automatic cycle(input string tag, input bit v,
                         input logic [7:0] d, input bit a);
        RX_VALID       = v;
        RX_DATA        = d;
        CONSOLE_IN_ack = a;
        model_step(v, d, a);
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        RESETn         = 1'b0;
        RX_VALID       = 1'b0;
        RX_DATA        = 8'h00;
        CONSOLE_IN_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        RESETn = 1'b1;
    endtask

    // One ack pulse: high two cycles, low two cycles
    task automatic ack_pulse(input string tag);
        cycle(tag, 1'b0, 8'h00, 1'b1);
        cycle(tag, 1'b0, 8'h00, 1'b1);
        cycle(tag, 1'b0, 8'h00, 1'b0);
        cycle(tag, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // single byte
        cycle("single_wr", 1'b1, 8'h50, 1'b0);
        cycle("single_show", 1'b0, 8'h00, 1'b0);
        chk("single_byte", CONSOLE_IN, 8'h50);
        cycle("single_ack", 1'b0, 8'h00, 1'b1);
        chk("single_popcnt", COUNT, 0);
        cycle("single_rel", 1'b0, 8'h00, 1'b0);

        // ordered burst
        cycle("burst_wr", 1'b1, 8'h50, 1'b0);
        cycle("burst_wr", 1'b1, 8'h41, 1'b0);
        cycle("burst_wr", 1'b1, 8'h0D, 1'b0);
        chk("burst_count", COUNT, 3);
        chk("burst_head", CONSOLE_IN, 8'h50);
        for (int i = 0; i < 3; i++) ack_pulse("burst_drain");
        chk("burst_empty", COUNT, 0);

        // full and overflow
        for (int i = 1; i <= 9; i++) cycle("ovf_wr", 1'b1, 8'(i), 1'b0);
        chk("ovf_flag", OVERFLOW, 1);
        chk("ovf_count", COUNT, 8);
        for (int i = 0; i < 8; i++) ack_pulse("ovf_drain");
        chk("ovf_sticky", OVERFLOW, 1);
        chk("ovf_notfull", FULL, 0);

        // simultaneous write and pop at full
        do_reset();
        for (int i = 0; i < 8; i++) cycle("sim_fill", 1'b1, 8'(8'h10 + i), 1'b0);
        cycle("sim_show", 1'b0, 8'h00, 1'b0);
        cycle("sim_both", 1'b1, 8'hAA, 1'b1);
        chk("sim_count", COUNT, 8);
        chk("sim_noovf", OVERFLOW, 0);
        cycle("sim_rel", 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) ack_pulse("sim_drain");
        chk("sim_last", CONSOLE_IN, 8'hAA);

        // stale ack, then wrap across pointers
        do_reset();
        cycle("stale_wr", 1'b1, 8'h33, 1'b1);
        cycle("stale_hold", 1'b0, 8'h00, 1'b1);
        cycle("stale_hold", 1'b0, 8'h00, 1'b1);
        chk("stale_novalid", CONSOLE_IN_valid, 0);
        cycle("stale_rel", 1'b0, 8'h00, 1'b0);
        cycle("stale_show", 1'b0, 8'h00, 1'b0);
        chk("stale_byte", CONSOLE_IN, 8'h33);
        ack_pulse("stale_pop");
        for (int i = 0; i < 20; i++)
            cycle("wrap", 1'b1, 8'(i), (i % 4) >= 2);
        for (int i = 0; i < 60; i++)
            cycle("wrap_drain", 1'b0, 8'h00, (i % 4) >= 2);
        chk("wrap_empty", COUNT, 0);

        // asynchronous reset mid-handshake
        for (int i = 0; i < 3; i++) cycle("mid_fill", 1'b1, 8'(8'h60 + i), 1'b0);
        cycle("mid_show", 1'b0, 8'h00, 1'b0);
        #3;
        RESETn = 1'b0;
        model_reset();
        #1;
        chk("mid_valid", CONSOLE_IN_valid, 0);
        chk("mid_count", COUNT, 0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        cycle("mid_new", 1'b1, 8'h41, 1'b0);
        cycle("mid_show2", 1'b0, 8'h00, 1'b0);
        chk("mid_first", CONSOLE_IN, 8'h41);
        ack_pulse("mid_pop");

        // random traffic with varying write pressure
        for (int seg = 0; seg < 6; seg++) begin
            int wp;
            wp = (seg % 3) * 35 + 15;
            for (int i = 0; i < 400; i++) begin
                bit v, a;
                v = ($urandom_range(0, 99) < wp);
                a = ($urandom_range(0, 1) == 1);
                cycle("rand", v, 8'($urandom), a);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/console_in_fifo.md
Name: console_in_fifo

Overview:
- Byte buffer and handshake adapter between the UART receiver and the processor Wrapper's console input port.
- Accepts one-cycle byte strobes from the UART RX, queues them, and presents them one at a time on CONSOLE_IN/CONSOLE_IN_valid.
- Uses the Wrapper's four-phase CONSOLE_IN_ack handshake, so keystrokes arriving while the processor is busy are not lost.

Parameters:
- DEPTH, 8, number of byte entries; must be a power of 2, minimum 2.
- ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  received byte from the UART; valid only while RX_VALID=1.
- RX_VALID  in  1  one-cycle write strobe from the UART.
- CONSOLE_IN  out  8  byte presented to the Wrapper.
- CONSOLE_IN_valid  out  1  CONSOLE_IN holds a byte for the Wrapper.
- CONSOLE_IN_ack  in  1  Wrapper acknowledge, level signal.
- COUNT  out  ADDR_W+1  bytes held in the FIFO, including the byte being presented.
- FULL  out  1  COUNT==DEPTH.
- OVERFLOW  out  1  sticky flag: at least one byte was dropped.

Behaviour:
- Reset (RESETn=0, asynchronous):
  - Read and write pointers = 0, COUNT=0, FULL=0, OVERFLOW=0.
  - CONSOLE_IN=8'h00, CONSOLE_IN_valid=0, state=IDLE.
  - Storage contents are don't-care.
  - Reset asserted mid-handshake aborts it. Bytes held are discarded.
- Write side:
  - Write happens on an edge where RX_VALID=1 and (COUNT<DEPTH or a pop occurs on the same edge).
  - Data goes to mem[wr_ptr]; wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
  - RX_VALID=1 while FULL with no same-edge pop: byte dropped, OVERFLOW set to 1. OVERFLOW clears only on reset.
- COUNT update:
  - +1 on a write alone.
  - -1 on a pop alone.
  - Unchanged on simultaneous write and pop.
- Output FSM, registered outputs:
  - IDLE: CONSOLE_IN_valid=0.
    - If COUNT>0 and CONSOLE_IN_ack=0: next edge loads CONSOLE_IN<=mem[rd_ptr], CONSOLE_IN_valid<=1, go PRESENT.
    - Waiting for ack=0 stops a stale ack from being taken for the new byte.
  - PRESENT: CONSOLE_IN and CONSOLE_IN_valid held stable.
    - On the first edge with CONSOLE_IN_ack=1: pop (rd_ptr+1 modulo DEPTH, COUNT-1), CONSOLE_IN_valid<=0, go WAIT_ACK_LOW.
    - CONSOLE_IN keeps its last value.
  - WAIT_ACK_LOW: CONSOLE_IN_valid=0.
    - On the first edge with CONSOLE_IN_ack=0: go IDLE.
- Latency:
  - A byte written at edge n into an empty FIFO, with ack low, appears on CONSOLE_IN with valid=1 after edge n+1.
  - Back-to-back bytes: minimum of 3 edges between valid assertions, with ack high for exactly one cycle.
- Ordering is strictly FIFO. There is no bypass path: a byte is always written before it is presented.
- A write on the same edge as the IDLE->PRESENT transition with COUNT=0 is not presented on that edge. It is presented from the next IDLE.
- No byte is popped without an ack. Ack outside PRESENT has no effect on the FIFO.
- FULL and COUNT are registered and reflect the state after the edge.

Test Plan:
- Reset then single byte: RESETn=0 for 2 cycles, check all outputs 0. Pulse RX_DATA=8'h50.
  - Required: CONSOLE_IN=8'h50, valid=1 one edge later.
  - Then raise ack: valid=0 next edge, COUNT=0. Drop ack: state returns to IDLE.
- Ordered burst: three consecutive RX strobes 8'h50, 8'h41, 8'h0D with ack held low.
  - Required: COUNT=3, CONSOLE_IN=8'h50.
  - Then three ack pulses, each held high 2 cycles and low 2 cycles.
  - Required: bytes presented in order 50, 41, 0D; each valid falls one edge after ack rises; COUNT ends at 0.
- Full and overflow with DEPTH=8: 9 strobes with ack low.
  - Required: FULL=1 after 8th, 9th byte dropped, OVERFLOW=1, COUNT=8.
  - Drain all 8: bytes 1-8 emerge; OVERFLOW stays 1 while FULL returns to 0.
- Simultaneous write/pop at full: FIFO full, strobe RX_DATA=8'hAA on the same edge the ack pop occurs.
  - Required: byte accepted, OVERFLOW=0, COUNT stays 8, 8'hAA emerges last.
- Stale ack and pointer wrap: hold ack=1 while writing into an empty FIFO.
  - Required: valid stays 0 until ack falls.
  - Push and pop 20 bytes 8'h00..8'h13 with an interleaved handshake: output sequence exact across the rd/wr pointer wrap.
- Reset mid-operation: COUNT=3 in PRESENT, assert RESETn=0 asynchronously between edges.
  - Required: valid=0 and COUNT=0 immediately.
  - After release, new byte 8'h41 is the first presented.
